// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit: signed/unsigned mult and div, mthi/mtlo, mfhi/mflo.
// Define MDU_FAST_MUL_EN for a single-cycle multiplier; otherwise multiply is 32-cycle shift-add.
module mul_div_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [1:0]  MULT,
  input  logic [1:0]  DIV,
  input  logic [1:0]  MTHL,
  input  logic [1:0]  MFHL,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] mfhl_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        is_div_q, is_div_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;

  logic        sgn_op;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] fix_prod;
`ifdef MDU_FAST_MUL_EN
  logic [63:0] fast_prod;
`endif

  always_comb begin
    sgn_op = (|DIV) ? ~DIV[1] : ~MULT[1];
    mag_a  = (sgn_op && src_a[31]) ? (~src_a + 32'd1) : src_a;
    mag_b  = (sgn_op && src_b[31]) ? (~src_b + 32'd1) : src_b;
    // acc holds {partial product, remaining multiplier} for mult, {remainder, quotient} for div
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    div_ge   = acc_q[63:31] >= {1'b0, b_q};
    div_diff = acc_q[62:31] - b_q;
    fix_prod = neg_q ? (~acc_q + 64'd1) : acc_q;
`ifdef MDU_FAST_MUL_EN
    fast_prod = {32'd0, mag_a} * {32'd0, mag_b};
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;

    unique case (state_q)
      S_IDLE: begin
        if (op_valid && !cancel) begin
          if (|DIV) begin
            if (src_b == '0) begin
              done_d = 1'b1;
            end else begin
              state_d  = S_DIV;
              cnt_d    = '0;
              acc_d    = {32'd0, mag_a};
              b_d      = mag_b;
              is_div_d = 1'b1;
              neg_d    = sgn_op & (src_a[31] ^ src_b[31]);
              rneg_d   = sgn_op & src_a[31];
            end
          end else if (|MULT) begin
`ifdef MDU_FAST_MUL_EN
            {hi_d, lo_d} = (sgn_op & (src_a[31] ^ src_b[31])) ? (~fast_prod + 64'd1) : fast_prod;
            done_d       = 1'b1;
`else
            state_d  = S_MUL;
            cnt_d    = '0;
            acc_d    = {32'd0, mag_b};
            b_d      = mag_a;
            is_div_d = 1'b0;
            neg_d    = sgn_op & (src_a[31] ^ src_b[31]);
            rneg_d   = 1'b0;
`endif
          end else begin
            if (MTHL[1]) hi_d = src_a;
            if (MTHL[0]) lo_d = src_a;
          end
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[31:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_DIV: begin
        acc_d = div_ge ? {div_diff, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          lo_d = neg_q  ? (~acc_q[31:0]  + 32'd1) : acc_q[31:0];
          hi_d = rneg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
        end else begin
          {hi_d, lo_d} = fix_prod;
        end
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (cancel && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign mfhl_data = MFHL[1] ? hi_q : (MFHL[0] ? lo_q : '0);

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: resetn  input  1  asynchronous active-low reset.
REQ-003 SHALL have port: op_valid  input  1  decoded HI/LO op presented this cycle.
REQ-004 SHALL have port: MULT  input  2  bit1 = multu, bit0 = mult.
REQ-005 SHALL have port: DIV  input  2  bit1 = divu, bit0 = div.
REQ-006 SHALL have port: MTHL  input  2  bit1 = mthi, bit0 = mtlo.
REQ-007 SHALL have port: MFHL  input  2  bit1 = mfhi, bit0 = mflo.
REQ-008 SHALL have port: src_a  input  32  rs operand (dividend / multiplicand / move source).
REQ-009 SHALL have port: src_b  input  32  rt operand (divisor / multiplier).
REQ-010 SHALL have port: cancel  input  1  flush; aborts any in-flight op.
REQ-011 SHALL have port: busy  output  1  multi-cycle op in flight; upstream stalls.
REQ-012 SHALL have port: done  output  1  one-cycle pulse after HI/LO updated by mult/div.
REQ-013 SHALL have port: mfhl_data  output  32  read data for mfhi/mflo.
REQ-014 SHALL have ports: hi, lo  output  32 each  architectural HI/LO registers.

Function
REQ-015 SHALL implement FSM states IDLE, MUL, DIV, FIX; busy = (state != IDLE).
REQ-016 SHALL accept an op only on an edge with op_valid=1, busy=0 and cancel=0; op_valid while busy SHALL be ignored.
REQ-017 SHALL resolve multiple asserted op bits by priority DIV > MULT > MTHL; within DIV/MULT, bit1 (unsigned) beats bit0.
REQ-018 SHALL write src_a to HI (MTHL[1]) and/or LO (MTHL[0]) at the accept edge, no busy, no done.
REQ-019 SHALL drive mfhl_data combinationally: MFHL[1] -> hi, else MFHL[0] -> lo, else 0; values are current register contents.
REQ-020 SHALL perform division as 32-iteration restoring division on operand magnitudes (DIV state, one quotient bit per cycle), then one FIX cycle: quotient negated if signs differ (div only), remainder takes dividend sign (div only); LO = quotient, HI = remainder.
REQ-021 SHALL, for div/divu, hold busy=1 for 33 cycles after the accept edge E0, write HI/LO at edge E33, assert done in the cycle after E33.
REQ-022 SHALL complete div/divu with src_b=0 without entering DIV: HI/LO unchanged, busy never set, done pulses the cycle after E0.
REQ-023 SHALL produce 64-bit product {HI,LO}: signed for mult, unsigned for multu; 0x80000000 operands handled without overflow.
REQ-024 SHALL, on cancel=1 at any edge with busy=1, return to IDLE, leave HI/LO unchanged, and suppress done.
REQ-025 SHALL keep done=0 except for the single pulse cycle; done and a new accept in that cycle are legal.

Reset
REQ-026 SHALL on resetn=0, immediately and independently of clk, set state=IDLE, hi=0, lo=0, busy=0, done=0, clear all iteration counters/partials.
REQ-027 SHALL abort any in-flight op on reset with no done pulse after release.

Configuration
REQ-028 SHALL honour macro MDU_FAST_MUL_EN: defined -> single-cycle multiply, HI/LO written at E0, busy never set, done the cycle after E0.
REQ-029 SHALL, without MDU_FAST_MUL_EN, multiply by 32-cycle shift-add on magnitudes (MUL state) plus one FIX sign cycle; timing identical to REQ-021.

Verification
REQ-030 SHALL test mult src_a=0xFFFFFFFD, src_b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; multu 0xFFFFFFFF x 2 -> HI=0x00000001, LO=0xFFFFFFFE; latency per build macro.
REQ-031 SHALL test div src_a=0xFFFFFFF9 (-7), src_b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, busy exactly 33 cycles, done in cycle 34.
REQ-032 SHALL test divu src_a=0x80000000, src_b=0 with HI=0x11, LO=0x22 preloaded -> HI/LO unchanged, busy=0, done next cycle.
REQ-033 SHALL test mthi 0x00001234 then mflo/mfhi -> mfhl_data=0x00001234 on mfhi the next cycle, LO unchanged.
REQ-034 SHALL test cancel at cycle 10 of divu 100/7 -> no done, HI/LO unchanged, new divu accepted next cycle yields LO=14, HI=2.
REQ-035 SHALL test resetn low at cycle 5 of div -> hi=lo=0, busy=0 asynchronously, no done after release.
